con_window_gen: RTL and testbench

Streaming 7x7 window generator that feeds the `con` convolution engine. It accepts one 8-bit image pixel per cycle in raster order, buffers the six previous image rows in line buffers, and presents each complete 7x7 neighbourhood as a packed 49-lane `ima` bus with a one-cycle `enable` strobe. Windows are "valid" convolution only, with no padding. Weights and bias are not handled here; they are driven alongside by the layer controller.

---
 rtl/con_window_gen.sv | 136 +++++++++++++
 tb/tb_con_window_gen.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/con_window_gen.sv
// Streaming 7x7 window generator for the con convolution engine.
// Takes one pixel per cycle in raster order, keeps the six previous image
// rows in line buffers, and emits every complete 7x7 neighbourhood as a
// packed 49-lane bus with a one-cycle enable strobe ("valid" windows only).
module con_window_gen #(
  parameter int IMA    = 8,
  parameter int K      = 7,
  parameter int WIDTH  = 28,
  parameter int HEIGHT = 28
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        pix_valid,
  input  logic [IMA-1:0]              pix_in,
  output logic [IMA*K*K-1:0]          ima,
  output logic                        enable,
  output logic [$clog2(HEIGHT)-1:0]   win_row,
  output logic [$clog2(WIDTH)-1:0]    win_col,
  output logic                        frame_done
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);

  // Input raster position of the pixel currently on pix_in.
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;

  // Line buffers: row 0 is the previous image row, row K-2 the oldest.
  logic [IMA-1:0] lb_mem [K-1][WIDTH];

  // Window shift array and its next state.
  logic [IMA-1:0] win_q [K][K];
  logic [IMA-1:0] win_d [K][K];
  logic [IMA*K*K-1:0] ima_d;

  // Registered outputs.
  logic [IMA*K*K-1:0] ima_q;
  logic               enable_q;
  logic               frame_done_q;
  logic [RW-1:0]      win_row_q;
  logic [CW-1:0]      win_col_q;

  logic last_col;
  logic last_row;
  logic complete;

  assign last_col = (col_q == CW'(WIDTH - 1));
  assign last_row = (row_q == RW'(HEIGHT - 1));
  // Both gates together keep windows from straddling a row wrap or a frame.
  assign complete = (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1));

  // Next window: shift every row left, load the vertical taps into column K-1.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    win_d = win_q;
    ima_d = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        win_d[r][c] = win_q[r][c+1];
      end
    end
    for (int r = 0; r < K - 1; r++) begin
      win_d[r][K-1] = lb_mem[K-2-r][col_q];
    end
    win_d[K-1][K-1] = pix_in;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        ima_d[(r*K+c)*IMA +: IMA] = win_d[r][c];
      end
    end
  end

  // Line-buffer cascade: each accepted pixel pushes its column one row older.
  // NOTE: the RAM has no reset; stale contents are never emitted because the
  // row gate only opens once six fresh rows of the current frame are stored.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      for (int k = 0; k < K - 2; k++) begin
        lb_mem[k+1][col_q] <= lb_mem[k][col_q];
      end
      lb_mem[0][col_q] <= pix_in;
    end
  end

  // Raster counters advance only on accepted pixels; row wrap starts a new frame.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (pix_valid) begin
      if (last_col) begin
        col_q <= '0;
        row_q <= last_row ? '0 : row_q + RW'(1);
      end else begin
        col_q <= col_q + CW'(1);
      end
    end
  end

  // Window array and registered outputs; ima/win_* hold until the next window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win_q[r][c] <= '0;
        end
      end
      ima_q        <= '0;
      enable_q     <= 1'b0;
      frame_done_q <= 1'b0;
      win_row_q    <= '0;
      win_col_q    <= '0;
    end else begin
      enable_q     <= pix_valid && complete;
      frame_done_q <= pix_valid && last_row && last_col;
      if (pix_valid) begin
        win_q <= win_d;
        if (complete) begin
          ima_q     <= ima_d;
          win_row_q <= row_q - RW'(K - 1);
          win_col_q <= col_q - CW'(K - 1);
        end
      end
    end
  end

  assign ima        = ima_q;
  assign enable     = enable_q;
  assign frame_done = frame_done_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;

endmodule

// File: tb/tb_con_window_gen.sv
// Bench for con_window_gen on an 8x8 image: directed frames, back-to-back
// frames, input gaps, mid-frame reset and random frames, all compared
// against a window model built from a stored copy of the image.
module tb_con_window_gen;

  localparam int IMA = 8;
  localparam int K   = 7;
  localparam int W   = 8;
  localparam int H   = 8;
  localparam int NL  = K * K;
  localparam int BW  = NL * IMA;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     pix_valid;
  logic [IMA-1:0]           pix_in;
  logic [BW-1:0]            ima;
  logic                     enable;
  logic [$clog2(H)-1:0]     win_row;
  logic [$clog2(W)-1:0]     win_col;
  logic                     frame_done;

  con_window_gen #(.IMA(IMA), .K(K), .WIDTH(W), .HEIGHT(H)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_valid  (pix_valid),
    .pix_in     (pix_in),
    .ima        (ima),
    .enable     (enable),
    .win_row    (win_row),
    .win_col    (win_col),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the image as written so far plus the raster position.
  logic [IMA-1:0] img [H][W];
  int             mr = 0;
  int             mc = 0;
  logic [BW-1:0]  held_ima = '0;
  int             held_row = 0;
  int             held_col = 0;
  int             win_cnt  = 0;
  int             gap_tick = 0;

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, then compare all outputs 1 ns after posedge.
  task automatic step(input bit v, input logic [IMA-1:0] px);
    bit exp_en;
    bit exp_fd;
    exp_en = 1'b0;
    exp_fd = 1'b0;
    @(negedge clk);
    pix_valid = v;
    pix_in    = px;
    if (v) begin
      img[mr][mc] = px;
      exp_en = (mr >= K - 1) && (mc >= K - 1);
      exp_fd = (mr == H - 1) && (mc == W - 1);
      if (exp_en) begin
        for (int n = 0; n < NL; n++)
          held_ima[n*IMA +: IMA] = img[mr-(K-1)+n/K][mc-(K-1)+n%K];
        held_row = mr - (K - 1);
        held_col = mc - (K - 1);
      end
      if (mc == W - 1) begin
        mc = 0;
        mr = (mr == H - 1) ? 0 : mr + 1;
      end else begin
        mc = mc + 1;
      end
    end
    @(posedge clk);
    #1;
    check("enable", BW'(enable), BW'(exp_en));
    check("frame_done", BW'(frame_done), BW'(exp_fd));
    check("ima", ima, held_ima);
    check("win_row", BW'(win_row), BW'(held_row));
    check("win_col", BW'(win_col), BW'(held_col));
    if (enable) win_cnt++;
  endtask

  function automatic logic [IMA-1:0] pix_of(input int kind, input int r, input int c);
    case (kind)
      0:       return IMA'(r * W + c);
      1:       return IMA'(8'hFF - (r * W + c));
      default: return IMA'($urandom_range(0, 255));
    endcase
  endfunction

  // gap_mode: 0 none, 1 every third cycle idle, 2 random idles.
  task automatic run_pixels(input int kind, input int gap_mode, input int npix);
    int sent;
    sent = 0;
    while (sent < npix) begin
      gap_tick++;
      if ((gap_mode == 1 && gap_tick % 3 == 0) ||
          (gap_mode == 2 && $urandom_range(0, 3) == 0)) begin
        step(1'b0, IMA'($urandom_range(0, 255)));
      end else begin
        step(1'b1, pix_of(kind, mr, mc));
        sent++;
      end
    end
  endtask

  task automatic run_frame(input string tag, input int kind, input int gap_mode);
    win_cnt = 0;
    run_pixels(kind, gap_mode, W * H);
    check(tag, BW'(win_cnt), BW'((W - K + 1) * (H - K + 1)));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_enable"}, BW'(enable), '0);
    check({tag, "_frame_done"}, BW'(frame_done), '0);
    check({tag, "_ima"}, ima, '0);
    check({tag, "_win_row"}, BW'(win_row), '0);
    check({tag, "_win_col"}, BW'(win_col), '0);
  endtask

  initial begin
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    pix_in    = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic frame, then an inverted frame with no idle cycle in between.
    run_frame("count_basic", 0, 0);
    run_frame("count_b2b", 1, 0);

    // Same basic frame with pix_valid low every third cycle.
    run_frame("count_gaps", 0, 1);

    // Abort mid-frame after 40 pixels; outputs must clear while reset is low.
    run_pixels(0, 0, 40);
    @(negedge clk);
    pix_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    check_reset_outputs("midreset_async");
    @(posedge clk);
    #1;
    check_reset_outputs("midreset_held");
    @(negedge clk);
    rst_n    = 1'b1;
    mr       = 0;
    mc       = 0;
    held_ima = '0;
    held_row = 0;
    held_col = 0;
    run_frame("count_after_reset", 0, 0);

    // Random pixels with random idle cycles over several frames.
    for (int f = 0; f < 4; f++)
      run_frame("count_random", 2, 2);

    // Idle tail: outputs must hold and no stray strobes appear.
    for (int i = 0; i < 4; i++)
      step(1'b0, IMA'($urandom_range(0, 255)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
